// File: rtl/fft_oflow_monitor.sv
// ----------------------------------------------------------------------------
// fft_oflow_monitor
//
// Per-frame overflow monitor for the PFB/FFT path. Frames are delimited by the
// FFT sync pulse. The block counts how many samples in each frame carried the
// FFT overflow flag, and keeps a sticky record of any frame that overflowed.
// It also checks that sync pulses arrive exactly every FRAME_LEN cycles.
// The result is a registered 32-bit status word for the software register
// that reports FFT overflow.
//
// Parameters:
//   FRAME_LEN      nominal number of cycles between sync pulses (>= 2)
//
// Ports:
//   user_clk       sole clock (FFT data clock)
//   user_rst_n     asynchronous active-low reset
//   sync_in        one-cycle pulse marking sample 0 of a frame
//   fft_oflow      FFT overflow flag for the current sample
//   clear          one-cycle synchronous pulse; zeroes the status word and
//                  the running accumulator
//   user_data_out  status word, taken straight from flops:
//                    [31]    sticky overflow since the last clear
//                    [30]    last completed frame had an overflow
//                    [29]    sticky sync error
//                    [28:16] frames with an overflow (saturates at 0x1FFF)
//                    [15:0]  overflow samples in last completed frame
//                            (saturates at 0xFFFF)
// ----------------------------------------------------------------------------
module fft_oflow_monitor #(
    parameter int FRAME_LEN = 256
) (
    input  logic        user_clk,
    input  logic        user_rst_n,
    input  logic        sync_in,
    input  logic        fft_oflow,
    input  logic        clear,
    output logic [31:0] user_data_out
);

    // Sample counter width; the guard keeps the width legal for degenerate
    // parameter values even though FRAME_LEN is expected to be at least 2.
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        COUNT     = 1'b1
    } stateT;

    stateT            r_state;
    stateT            w_stateNext;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic [15:0]      r_acc;
    logic [15:0]      w_accNext;

    // Fields of the status word
    logic             r_stickyOflow;
    logic             w_stickyOflowNext;
    logic             r_lastOflow;
    logic             w_lastOflowNext;
    logic             r_syncErr;
    logic             w_syncErrNext;
    logic [12:0]      r_frameCnt;
    logic [12:0]      w_frameCntNext;
    logic [15:0]      r_lastCount;
    logic [15:0]      w_lastCountNext;

    // Helper values shared by the next-state logic
    logic             w_cntLast;
    logic [CNT_W-1:0] w_cntInc;
    logic [15:0]      w_accInc;
    logic [15:0]      w_accSync;
    logic [12:0]      w_frameCntInc;
    logic             w_accNonZero;

    // Precompute the saturating and wrapping increments so that the
    // next-state process below reads as a plain priority list of events.
    // On a sync cycle the accumulator restarts from that cycle's flag,
    // because the sync sample is sample 0 of the new frame.
    always_comb begin
        w_cntLast     = (r_cnt == CNT_LAST);
        w_cntInc      = w_cntLast ? '0 : (r_cnt + CNT_W'(1));
        w_accInc      = (fft_oflow && (r_acc != 16'hFFFF)) ? (r_acc + 16'd1) : r_acc;
        w_accSync     = {15'd0, fft_oflow};
        w_frameCntInc = (r_frameCnt == 13'h1FFF) ? r_frameCnt : (r_frameCnt + 13'd1);
        w_accNonZero  = (r_acc != 16'd0);
    end

    // Next-state logic. Events are handled in priority order:
    //   1. clear   - zero the status word and accumulator. A sync in the same
    //                cycle still starts a frame but closes nothing and cannot
    //                raise a sync error. Otherwise the counter keeps running.
    //   2. sync    - restart the sample counter. In COUNT this closes the
    //                previous frame and checks that the sync arrived on the
    //                last sample of the nominal frame. In WAIT_SYNC it only
    //                starts counting.
    //   3. no sync - in COUNT, accumulate overflows and advance the counter.
    //                Wrapping past the last sample means a sync was missed.
    //                That is flagged, but the frame stays open and keeps
    //                accumulating until a sync finally arrives.
    always_comb begin
        w_stateNext       = r_state;
        w_cntNext         = r_cnt;
        w_accNext         = r_acc;
        w_stickyOflowNext = r_stickyOflow;
        w_lastOflowNext   = r_lastOflow;
        w_syncErrNext     = r_syncErr;
        w_frameCntNext    = r_frameCnt;
        w_lastCountNext   = r_lastCount;

        if (clear) begin
            w_accNext         = 16'd0;
            w_stickyOflowNext = 1'b0;
            w_lastOflowNext   = 1'b0;
            w_syncErrNext     = 1'b0;
            w_frameCntNext    = 13'd0;
            w_lastCountNext   = 16'd0;
            if (sync_in) begin
                w_cntNext   = '0;
                w_stateNext = COUNT;
            end else if (r_state == COUNT) begin
                w_cntNext = w_cntInc;
            end
        end else if (sync_in) begin
            w_cntNext   = '0;
            w_stateNext = COUNT;
            w_accNext   = w_accSync;
            if (r_state == COUNT) begin
                w_lastCountNext = r_acc;
                w_lastOflowNext = w_accNonZero;
                if (w_accNonZero) begin
                    w_stickyOflowNext = 1'b1;
                    w_frameCntNext    = w_frameCntInc;
                end
                if (!w_cntLast) begin
                    w_syncErrNext = 1'b1;
                end
            end
        end else if (r_state == COUNT) begin
            w_cntNext = w_cntInc;
            w_accNext = w_accInc;
            if (w_cntLast) begin
                w_syncErrNext = 1'b1;
            end
        end
    end

    // State and datapath registers. Reset drops any partial frame and
    // returns to WAIT_SYNC, so overflow flags are ignored until the FFT
    // delivers a fresh sync.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_state       <= WAIT_SYNC;
            r_cnt         <= '0;
            r_acc         <= 16'd0;
            r_stickyOflow <= 1'b0;
            r_lastOflow   <= 1'b0;
            r_syncErr     <= 1'b0;
            r_frameCnt    <= 13'd0;
            r_lastCount   <= 16'd0;
        end else begin
            r_state       <= w_stateNext;
            r_cnt         <= w_cntNext;
            r_acc         <= w_accNext;
            r_stickyOflow <= w_stickyOflowNext;
            r_lastOflow   <= w_lastOflowNext;
            r_syncErr     <= w_syncErrNext;
            r_frameCnt    <= w_frameCntNext;
            r_lastCount   <= w_lastCountNext;
        end
    end

    // The status word is a pure concatenation of flops, with no logic
    // between the registers and the software register input.
    assign user_data_out = {r_stickyOflow, r_lastOflow, r_syncErr, r_frameCnt, r_lastCount};

endmodule

// File: tb/tb_fft_oflow_monitor.sv
// ----------------------------------------------------------------------------
// tb_fft_oflow_monitor
//
// Directed bench for fft_oflow_monitor. Three instances share the clock and
// reset:
//   dutA  FRAME_LEN=16     nominal counting, sync errors, clear collision,
//                          asynchronous reset, back-to-back syncs
//   dutS  FRAME_LEN=2^17   per-frame sample count saturation at 0xFFFF
//   dutF  FRAME_LEN=2      frame count saturation at 0x1FFF
// Expected status words are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_fft_oflow_monitor;

    logic        clk;
    logic        rstN;

    logic        syncA, oflowA, clearA;
    logic [31:0] outA;
    logic        syncS, oflowS;
    logic [31:0] outS;
    logic        syncF, oflowF;
    logic [31:0] outF;

    int checkCount;
    int passCount;

    fft_oflow_monitor #(.FRAME_LEN(16)) dutA (
        .user_clk      (clk),
        .user_rst_n    (rstN),
        .sync_in       (syncA),
        .fft_oflow     (oflowA),
        .clear         (clearA),
        .user_data_out (outA)
    );

    fft_oflow_monitor #(.FRAME_LEN(131072)) dutS (
        .user_clk      (clk),
        .user_rst_n    (rstN),
        .sync_in       (syncS),
        .fft_oflow     (oflowS),
        .clear         (1'b0),
        .user_data_out (outS)
    );

    fft_oflow_monitor #(.FRAME_LEN(2)) dutF (
        .user_clk      (clk),
        .user_rst_n    (rstN),
        .sync_in       (syncF),
        .fft_oflow     (oflowF),
        .clear         (1'b0),
        .user_data_out (outF)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one active edge and settle, so outputs are sampled 1 ns after
    // the edge and new inputs are stable well before the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus into dutA
    task automatic applyStimulus(input logic s, input logic o, input logic c);
        syncA  = s;
        oflowA = o;
        clearA = c;
        tick();
        syncA  = 1'b0;
        oflowA = 1'b0;
        clearA = 1'b0;
    endtask

    // Compare one status word against its hand-computed value
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rstN   = 1'b0;
        syncA  = 1'b0; oflowA = 1'b0; clearA = 1'b0;
        syncS  = 1'b0; oflowS = 1'b0;
        syncF  = 1'b0; oflowF = 1'b0;

        // Reset state
        tick();
        tick();
        checkOutput("reset_A", outA, 32'h0000_0000);
        checkOutput("reset_S", outS, 32'h0000_0000);
        checkOutput("reset_F", outF, 32'h0000_0000);
        rstN = 1'b1;

        // Overflows before the first sync are ignored
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("wait_sync_ignore", outA, 32'h0000_0000);

        // First sync closes no frame
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("first_sync", outA, 32'h0000_0000);

        // Frame 1: three overflows, still open before the next sync
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, (i < 3), 1'b0);
        checkOutput("frame1_open", outA, 32'h0000_0000);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("nominal_frame1", outA, 32'hC001_0003);

        // Frame 2: clean
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("nominal_frame2", outA, 32'h8001_0000);

        // Sync five cycles early, two overflows in the short frame
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, (i == 2 || i == 7), 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("early_sync", outA, 32'hE002_0002);

        // Clear and sync together mid-frame with overflow high
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("clear_with_sync", outA, 32'h0000_0000);

        // Next frame starts at cnt=0 with acc=0: nominal close, two overflows
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, (i == 4 || i == 9), 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("after_clear", outA, 32'hC001_0002);

        // Missed sync: counter wraps without a sync, frame stays open
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, (i == 1 || i == 6 || i == 11), 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("missed_sync", outA, 32'hE001_0002);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("missed_sync_close", outA, 32'hE002_0004);

        // Asynchronous reset between clock edges, mid-frame
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async_reset", outA, 32'h0000_0000);
        tick();
        rstN = 1'b1;

        // After reset: pre-sync overflows ignored, first sync closes nothing
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("post_reset_ignore", outA, 32'h0000_0000);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("post_reset_first_sync", outA, 32'h0000_0000);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("post_reset_frame", outA, 32'hC001_0001);

        // Back-to-back syncs: each closes a frame, the second is an error
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("b2b_sync_1", outA, 32'hA001_0000);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("b2b_sync_2", outA, 32'hE002_0001);

        // Saturation: dutS holds overflow high for a long frame while dutF
        // closes one overflowing frame every two cycles.
        $display("[TB] saturation phase");
        for (int i = 0; i <= 65600; i++) begin
            syncS  = (i == 0);
            oflowS = 1'b1;
            syncF  = (i <= 16400) && (i % 2 == 0);
            oflowF = (i <= 16400);
            tick();
            if (i == 16380) checkOutput("frame_cnt_1ffe", outF, 32'hDFFE_0002);
            if (i == 16400) checkOutput("frame_cnt_sat", outF, 32'hDFFF_0002);
        end
        syncF  = 1'b0;
        oflowF = 1'b0;
        checkOutput("sat_frame_open", outS, 32'h0000_0000);
        syncS  = 1'b1;
        oflowS = 1'b0;
        tick();
        syncS  = 1'b0;
        checkOutput("sample_cnt_sat", outS, 32'hE001_FFFF);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fft_oflow_monitor.md
# fft_oflow_monitor

Per-frame FFT overflow monitor for the PFB/FFT path. It counts the overflow flags asserted by the FFT during each frame, delimited by the FFT sync pulse. It also checks that sync pulses arrive at the nominal frame period. It publishes a registered 32-bit status word that feeds the `user_data_in` port of the `pfb_fft_check_fft_oflow` software register.

## Interface
Parameters:
- `FRAME_LEN`, default 256: nominal cycles between sync pulses; must be ≥ 2. The sample counter width is clog2(FRAME_LEN).

Ports:
- `user_clk`  in  1  sole clock; the FFT data clock.
- `user_rst_n`  in  1  reset, asynchronous, active-low.
- `sync_in`  in  1  one-cycle pulse; marks sample 0 of a frame.
- `fft_oflow`  in  1  FFT overflow flag for the current sample.
- `clear`  in  1  one-cycle pulse, already synchronous to `user_clk`. Zeroes all counters and flags.
- `user_data_out`  out  32  status word, driven straight from flops. Fields:
  - [31] sticky overflow (any frame since clear).
  - [30] the last completed frame had an overflow.
  - [29] sticky sync error.
  - [28:16] count of frames with an overflow; 13-bit, saturates at 0x1FFF.
  - [15:0] overflow samples in the last completed frame; saturates at 0xFFFF.

## Operation
- States:
  - WAIT_SYNC: reset state. `fft_oflow` is ignored and the accumulator is held at 0.
  - COUNT: entered on the first `sync_in`; COUNT is never left except by reset.
- Sample counter `cnt`:
  - A sync cycle loads `cnt` = 0.
  - Otherwise, in COUNT, `cnt` increments by 1 and wraps from FRAME_LEN-1 to 0.
- Accumulator `acc` (16 bit, saturating):
  - In COUNT, each cycle with `fft_oflow`=1 adds 1.
  - At 0xFFFF, `acc` holds.
- Sync in COUNT closes the previous frame:
  - [15:0] ← `acc`.
  - [30] ← (`acc` != 0).
  - If `acc` != 0: [31] ← 1, and [28:16] increments, saturating.
  - `acc` restarts at `fft_oflow` of the sync cycle, so the sync sample belongs to the new frame.
- The first sync, arriving in WAIT_SYNC, closes no frame. The output is unchanged and `acc` ← `fft_oflow` of that cycle.
- Sync error, which sets [29] sticky:
  - A sync arrives in COUNT while `cnt` != FRAME_LEN-1 (early sync).
  - `cnt` wraps FRAME_LEN-1→0 with no sync on the wrap cycle (missed sync). In that case no frame is closed and `acc` keeps accumulating.
- A sync is still honoured when it raises a sync error: the frame closes and `cnt` ← 0.
- `clear` has priority over every other update in the same cycle:
  - `user_data_out` and `acc` are zeroed, and that cycle's `fft_oflow` is discarded.
  - State and `cnt` are not cleared.
  - If `sync_in` is also high, `cnt` ← 0 and the state goes to COUNT, but no frame is closed and no sync error is flagged.
- Reset: state = WAIT_SYNC, `cnt` = 0, `acc` = 0, `user_data_out` = 0x00000000.

## Timing
- All outputs are registered. A frame closed by the sync sampled on edge N is visible on `user_data_out` after edge N; latency is 1 cycle from the `sync_in` assertion.
- The sticky bits and the [28:16] count update on that same edge.
- A `clear` sampled on edge N zeroes the output after edge N.
- Asynchronous reset:
  - Assertion forces reset values immediately, independent of `user_clk`.
  - Deassertion is synchronous: it is assumed to be synchronised externally to `user_clk`.
- Reset asserted mid-frame discards the partial frame. Operation resumes in WAIT_SYNC.
- Back-to-back syncs on consecutive cycles, with FRAME_LEN > 1:
  - Each sync closes a frame.
  - The second sync flags a sync error, because `cnt` = 0 ≠ FRAME_LEN-1.
- Throughput is one sample per cycle with no stalls. `fft_oflow` may be high on every cycle.

## Test plan
- Nominal counting, FRAME_LEN=16. Stimulus: reset, syncs every 16 cycles, 3 overflows in frame 1, 0 in frame 2.
  - After the 2nd sync, out = 0xC0010003.
  - After the 3rd sync, out = 0x80010000.
  - [29] stays 0 throughout.
- Saturation, FRAME_LEN=2^17 override. Stimulus: `fft_oflow` held high for a full frame.
  - [15:0] = 0xFFFF.
  - [28:16] = 1.
  - Frame-count saturation, checked with 8200 overflowing frames: [28:16] holds at 0x1FFF.
- Sync errors. Stimulus: a sync 5 cycles early.
  - [29]=1, and the frame closes with the counts up to that point.
  - Separately, a missing sync sets [29] with the frame left open: [15:0] unchanged until the next sync.
- Clear collision. Stimulus: `clear` and `sync_in` in the same cycle mid-run, with overflow also high.
  - out = 0, and [29] stays 0.
  - The next frame starts at `cnt`=0 with `acc`=0.
- Async reset mid-frame. Stimulus: assert `user_rst_n`=0 between clock edges.
  - out = 0 immediately.
  - `fft_oflow` before the first post-reset sync is ignored, and the first sync closes no frame.
